// File: rtl/row_deskew_collector_pkg.sv
// Shared constants for the row post-process path.
//   COL_NUM : lanes (systolic array columns)
//   DATA_W  : bits per lane (fp16)
//   ROW_W   : width of the row counter and tile_rows
package row_deskew_collector_pkg;

  localparam int unsigned COL_NUM = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ROW_W   = 8;

endpackage

// File: rtl/row_deskew_collector_lane_delay.sv
// lane_delay_line: fixed-depth shift register for one lane.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : lane input
//   q_o    : lane input delayed by Depth cycles (Depth 0 is a wire)
module lane_delay_line #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_pass
    assign q_o = d_i;
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
  end else if (Depth == 1) begin : g_one
    logic [Width-1:0] sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= d_i;
    end
    assign q_o = sr_q;
  end else begin : g_shift
    logic [Depth-1:0][Width-1:0] sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= {sr_q[Depth-2:0], d_i};
    end
    assign q_o = sr_q[Depth-1];
  end

endmodule

// File: rtl/row_deskew_collector.sv
// row_deskew_collector: realigns the diagonal fp16 wavefront into whole rows.
//   clk                 : clock, rising edge
//   rst_n               : asynchronous active-low reset
//   fp16_in_diagonal    : skewed lanes, lane i lags lane 0 by i cycles
//   fp16_valid_diagonal : lane 0 of the wavefront carries a valid element
//   tile_rows           : rows per tile, 0 means 2^ROW_W; latched at tile start
//   row_out             : aligned row, held while row_valid is low
//   row_valid           : row_out valid this cycle
//   row_idx             : row index within the tile
//   row_last            : final row of the tile
//   tile_done           : one-cycle pulse after the row_last beat
module row_deskew_collector
  import row_deskew_collector_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [COL_NUM*DATA_W-1:0]  fp16_in_diagonal,
  input  logic                       fp16_valid_diagonal,
  input  logic [ROW_W-1:0]           tile_rows,
  output logic [COL_NUM*DATA_W-1:0]  row_out,
  output logic                       row_valid,
  output logic [ROW_W-1:0]           row_idx,
  output logic                       row_last,
  output logic                       tile_done
);

  localparam logic [ROW_W-1:0] RowOne = ROW_W'(1);

  // Lane i waits COL_NUM-1-i cycles so all lanes line up with the last one.
  logic [COL_NUM*DATA_W-1:0] aligned;

  for (genvar i = 0; i < COL_NUM; i++) begin : g_lane
    lane_delay_line #(
      .Depth (COL_NUM - 1 - i),
      .Width (DATA_W)
    ) u_delay (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (fp16_in_diagonal[i*DATA_W +: DATA_W]),
      .q_o    (aligned[i*DATA_W +: DATA_W])
    );
  end

  // Input-side tile tracking. The last-row flag is decided here and travels
  // with the valid, so a new tile latching tile_rows cannot disturb rows of
  // the previous tile that are still in flight.
  logic [ROW_W-1:0] in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0] tile_rows_lat_q, tile_rows_lat_d;
  logic [ROW_W-1:0] rows_eff;
  logic             in_last;

  always_comb begin
    in_cnt_d        = in_cnt_q;
    tile_rows_lat_d = tile_rows_lat_q;
    rows_eff        = (in_cnt_q == '0) ? tile_rows : tile_rows_lat_q;
    in_last         = fp16_valid_diagonal && (in_cnt_q == rows_eff - RowOne);
    if (fp16_valid_diagonal) begin
      if (in_cnt_q == '0) tile_rows_lat_d = tile_rows;
      in_cnt_d = in_last ? '0 : in_cnt_q + RowOne;
    end
  end

  logic [COL_NUM-1:0] vld_q, last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q        <= '0;
      tile_rows_lat_q <= '0;
      vld_q           <= '0;
      last_q          <= '0;
    end else begin
      in_cnt_q        <= in_cnt_d;
      tile_rows_lat_q <= tile_rows_lat_d;
      vld_q           <= {vld_q[COL_NUM-2:0], fp16_valid_diagonal};
      last_q          <= {last_q[COL_NUM-2:0], in_last};
    end
  end

  // Output side.
  logic [COL_NUM*DATA_W-1:0] row_out_q;
  logic [ROW_W-1:0]          out_cnt_q, out_cnt_d;
  logic                      tile_done_q;

  assign row_valid = vld_q[COL_NUM-1];
  assign row_last  = row_valid && last_q[COL_NUM-1];
  assign row_idx   = out_cnt_q;
  assign row_out   = row_out_q;
  assign tile_done = tile_done_q;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (row_valid) out_cnt_d = row_last ? '0 : out_cnt_q + RowOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out_q   <= '0;
      out_cnt_q   <= '0;
      tile_done_q <= 1'b0;
    end else begin
      // Capture only when the row becoming visible next cycle is valid.
      if (vld_q[COL_NUM-2]) row_out_q <= aligned;
      out_cnt_q   <= out_cnt_d;
      tile_done_q <= row_last;
    end
  end

endmodule

// File: tb/tb_row_deskew_collector.sv
module tb_row_deskew_collector;
  import row_deskew_collector_pkg::*;

  localparam int MAXC = 320;
  localparam int BW   = COL_NUM * DATA_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] fp16_in_diagonal;
  logic          fp16_valid_diagonal;
  logic [7:0]    tile_rows;
  logic [BW-1:0] row_out;
  logic          row_valid;
  logic [7:0]    row_idx;
  logic          row_last;
  logic          tile_done;

  always #5 clk = ~clk;

  row_deskew_collector dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fp16_in_diagonal    (fp16_in_diagonal),
    .fp16_valid_diagonal (fp16_valid_diagonal),
    .tile_rows           (tile_rows),
    .row_out             (row_out),
    .row_valid           (row_valid),
    .row_idx             (row_idx),
    .row_last            (row_last),
    .tile_done           (tile_done)
  );

  typedef struct {
    int          scen;
    int          t0;    // cycle lane 0 of this row is driven
    logic [7:0]  tr;    // tile_rows driven from t0 onward
    logic [15:0] base;  // lane i data = base + i
    logic [7:0]  idx;   // required row_idx
    logic        last;  // required row_last
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;

  logic [BW-1:0] bus_s    [MAXC];
  logic          vld_s    [MAXC];
  logic [7:0]    tr_s     [MAXC];
  logic          exp_v    [MAXC];
  logic          exp_done [MAXC];
  logic [7:0]    exp_idx  [MAXC];
  logic          exp_last [MAXC];
  logic [15:0]   exp_base [MAXC];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h required %0h", nm, cur_cyc, act, req);
    end
  endtask

  function automatic logic [BW-1:0] mk_row(input logic [15:0] base);
    logic [BW-1:0] r;
    for (int i = 0; i < COL_NUM; i++) r[i*DATA_W +: DATA_W] = base + 16'(i);
    return r;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      bus_s[c]    = {COL_NUM{16'hDEAD}};
      vld_s[c]    = 1'b0;
      tr_s[c]     = 8'd0;
      exp_v[c]    = 1'b0;
      exp_done[c] = 1'b0;
      exp_idx[c]  = 8'd0;
      exp_last[c] = 1'b0;
      exp_base[c] = 16'd0;
    end
  endtask

  task automatic add_row(input int t0, input logic [7:0] tr, input logic [15:0] base,
                         input logic [7:0] idx, input logic last);
    vld_s[t0] = 1'b1;
    for (int c = t0; c < MAXC; c++) tr_s[c] = tr;
    for (int i = 0; i < COL_NUM; i++) bus_s[t0+i][i*DATA_W +: DATA_W] = base + 16'(i);
    exp_v[t0+COL_NUM]    = 1'b1;
    exp_idx[t0+COL_NUM]  = idx;
    exp_last[t0+COL_NUM] = last;
    exp_base[t0+COL_NUM] = base;
    if (last) exp_done[t0+COL_NUM+1] = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".row_valid"}, BW'(row_valid), '0);
    chk({tag, ".row_idx"},   BW'(row_idx),   '0);
    chk({tag, ".row_last"},  BW'(row_last),  '0);
    chk({tag, ".tile_done"}, BW'(tile_done), '0);
    chk({tag, ".row_out"},   row_out,        '0);
  endtask

  task automatic do_reset();
    fp16_valid_diagonal = 1'b0;
    fp16_in_diagonal    = '0;
    tile_rows           = 8'd0;
    rst_n               = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  // Drives the schedule; output state after the edge of cycle c is cycle c+1.
  task automatic run_sched(input int ncyc);
    int o;
    for (int c = 0; c < ncyc; c++) begin
      fp16_valid_diagonal = vld_s[c];
      fp16_in_diagonal    = bus_s[c];
      tile_rows           = tr_s[c];
      @(posedge clk);
      #1;
      o       = c + 1;
      cur_cyc = o;
      chk("row_valid", BW'(row_valid), BW'(exp_v[o]));
      chk("tile_done", BW'(tile_done), BW'(exp_done[o]));
      if (exp_v[o]) begin
        chk("row_idx",  BW'(row_idx),  BW'(exp_idx[o]));
        chk("row_last", BW'(row_last), BW'(exp_last[o]));
        chk("row_out",  row_out,       mk_row(exp_base[o]));
      end
    end
    fp16_valid_diagonal = 1'b0;
  endtask

  initial begin
    int last_t0;
    // Single skewed row: beat at 42, tile_done at 43.
    tbl.push_back('{0, 10, 8'd1, 16'h3C00, 8'd0, 1'b1});
    // Burst of 4 back-to-back rows.
    tbl.push_back('{1, 0, 8'd4, 16'h0000, 8'd0, 1'b0});
    tbl.push_back('{1, 1, 8'd4, 16'h0100, 8'd1, 1'b0});
    tbl.push_back('{1, 2, 8'd4, 16'h0200, 8'd2, 1'b0});
    tbl.push_back('{1, 3, 8'd4, 16'h0300, 8'd3, 1'b1});
    // Gapped valids at 0, 2, 5.
    tbl.push_back('{2, 0, 8'd3, 16'hA000, 8'd0, 1'b0});
    tbl.push_back('{2, 2, 8'd3, 16'hB000, 8'd1, 1'b0});
    tbl.push_back('{2, 5, 8'd3, 16'hC000, 8'd2, 1'b1});
    // Mid-tile tile_rows change to 2, then an abutting 2-row tile.
    tbl.push_back('{3, 0, 8'd4, 16'h1100, 8'd0, 1'b0});
    tbl.push_back('{3, 1, 8'd4, 16'h1200, 8'd1, 1'b0});
    tbl.push_back('{3, 2, 8'd2, 16'h1300, 8'd2, 1'b0});
    tbl.push_back('{3, 3, 8'd2, 16'h1400, 8'd3, 1'b1});
    tbl.push_back('{3, 4, 8'd2, 16'h1500, 8'd0, 1'b0});
    tbl.push_back('{3, 5, 8'd2, 16'h1600, 8'd1, 1'b1});

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      clear_sched();
      last_t0 = 0;
      foreach (tbl[k]) begin
        if (tbl[k].scen == s) begin
          add_row(tbl[k].t0, tbl[k].tr, tbl[k].base, tbl[k].idx, tbl[k].last);
          if (tbl[k].t0 > last_t0) last_t0 = tbl[k].t0;
        end
      end
      do_reset();
      run_sched(last_t0 + COL_NUM + 4);
    end

    // tile_rows=0: 256 contiguous rows, then a 2-row tile restarting at 0.
    clear_sched();
    for (int r = 0; r < 256; r++) add_row(r, 8'd0, 16'(r << 5), 8'(r), r == 255);
    add_row(256, 8'd2, 16'hE000, 8'd0, 1'b0);
    add_row(257, 8'd2, 16'hE100, 8'd1, 1'b1);
    do_reset();
    run_sched(257 + COL_NUM + 4);

    // Reset while row 2 of a 4-row tile is on the output.
    clear_sched();
    for (int r = 0; r < 4; r++) add_row(r, 8'd4, 16'h7000 + 16'(r << 8), 8'(r), r == 3);
    do_reset();
    run_sched(34);
    fp16_valid_diagonal = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sched();
    add_row(0, 8'd2, 16'h5500, 8'd0, 1'b0);
    add_row(1, 8'd2, 16'h5600, 8'd1, 1'b1);
    run_sched(1 + COL_NUM + 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_deskew_collector.md
Name: row_deskew_collector

Overview:
- Consumer end of the row post-process path: takes the 32-lane fp16 wavefront, still diagonal (lane i lags lane 0 by i cycles), and realigns it into whole rows.
- Emits one aligned 32x16-bit row per cycle, with a row index, a last-row flag and a tile-done pulse.
- Sits between the scaling stage and the Res/result-buffer writer. It is driven directly by the 3-cycle-delayed diagonal valid.

Parameters:
- COL_NUM, 32, number of lanes (columns of the systolic array).
- DATA_W, 16, bits per lane (fp16).
- ROW_W, 8, width of the row counter and tile_rows.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fp16_in_diagonal  input  COL_NUM*DATA_W  skewed lane data; lane i occupies bits [(i+1)*DATA_W-1 : i*DATA_W].
- fp16_valid_diagonal  input  1  high when lane 0 carries a valid element; lane i's matching element arrives i cycles later.
- tile_rows  input  ROW_W  number of rows in the current tile; value 0 means 2^ROW_W rows.
- row_out  output  COL_NUM*DATA_W  deskewed row; lane order is the same as the input.
- row_valid  output  1  row_out is valid this cycle.
- row_idx  output  ROW_W  index of the row within the tile, 0..tile_rows-1.
- row_last  output  1  high with row_valid on the final row of the tile.
- tile_done  output  1  one-cycle pulse, one cycle after the row_last beat.

Behaviour:
- Reset: clk and rst_n as named above, asynchronous active-low. Every output register, delay stage, valid pipe and counter clears to 0 when rst_n=0. On rst_n assertion mid-tile, all partial rows are discarded and the next valid starts a new tile at row 0.
- Deskew:
  - lane i passes through COL_NUM-1-i register stages; lane COL_NUM-1 has zero stages.
  - The aligned lanes are then captured in one output register.
  - Delay stages shift every cycle, unconditionally. There is no backpressure.
- Valid path: fp16_valid_diagonal goes through a COL_NUM-stage pipe and drives row_valid.
- Latency:
  - Lane 0 valid at cycle t gives row_valid at t+COL_NUM.
  - row_out lane i equals fp16_in_diagonal lane i sampled at cycle t+i.
- Throughput: one row per cycle. Back-to-back valids and gapped valids are both legal; gaps propagate unchanged.
- Row counter:
  - Increments on each output beat (row_valid=1).
  - row_idx on a beat is the count before the increment.
  - row_last = row_valid && (row_idx == tile_rows_lat-1), using ROW_W-bit wrap arithmetic, so tile_rows=0 makes the last index 2^ROW_W-1.
  - On the row_last beat the counter returns to 0.
- tile_rows latch: tile_rows is sampled into tile_rows_lat on an input valid beat while the input-side row count is 0, i.e. at tile start. Changes mid-tile are ignored.
- Tile boundary: a new tile's first input valid may arrive on the cycle right after the previous tile's last input valid. Output is then continuous: row_last is followed immediately by row_idx=0 of the next tile.
- tile_done is a registered copy of the row_last beat (one cycle after it). It does not overlap with itself.
- Inputs while row_valid=0 are don't-care. row_out holds its last value when invalid.

Decomposition:
- Shared package: COL_NUM and DATA_W constants, matching the post-process stage. No typedefs are needed.
- One sub-module: lane_delay_line, a shift register parameterised by depth and width.
  - Depth 0 is a pass-through.
  - Instantiated per lane in a generate loop with depth COL_NUM-1-i.

Test Plan:
- Skewed single row: tile_rows=1; lane 0 valid at t=10, lane i data = 16'h3C00+i driven at cycle 10+i. Required: row_valid at 42; row_out lane i = 3C00+i; row_idx=0; row_last=1; tile_done at 43.
- Burst of 4 back-to-back rows: tile_rows=4; row r lane i = {r[7:0], i[7:0]}. Required: 4 consecutive beats with row_idx 0,1,2,3, lanes correct, row_last only on idx 3.
- Gapped valid: tile_rows=3; valids at cycles 0, 2 and 5. Required: beats at 32, 34 and 37 with the same gaps, no spurious row_valid, last on the third beat.
- tile_rows=0 wrap: feed 256 contiguous rows. Required: idx runs 0..255, row_last at idx 255, tile_done once; the next tile restarts at idx 0.
- Mid-tile tile_rows change: latch 4, then drive tile_rows=2 after row 1 is input. Required: the tile still ends at idx 3.
- Reset mid-tile: assert rst_n=0 during row 2 of 4. Required: all outputs 0 immediately; after release a new tile of 2 rows gives idx 0,1 with row_last on idx 1 and no stale rows.
